psum_norm_unit: RTL and testbench

- Normalization stage that sits directly downstream of the partial-sum memory (pmem) read port in the core.
- Accepts one row of col signed dot-product results and sums their absolute values.
- Divides each entry by the truncated sum abs_sum >> norm_shift using one shared serial divider.
- Returns the normalized row for pmem write-back; this is the operation the chip-level norm instruction step performs.

---
 rtl/norm_pkg.sv | 20 ++
 rtl/serial_divider.sv | 81 ++++++++
 rtl/psum_norm_unit.sv | 160 ++++++++++++++++
 tb/tb_psum_norm_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/norm_pkg.sv
// Shared constants and state encoding for the partial-sum normalization unit.
// Defaults: 20-bit partial sums, 8 entries per row, divisor = abs_sum >> 7.
package norm_pkg;

  localparam int unsigned BW_PSUM    = 20;
  localparam int unsigned COL        = 8;
  localparam int unsigned NORM_SHIFT = 7;

  // abs_sum needs 4 guard bits above one entry so a full row of magnitudes cannot overflow.
  localparam int unsigned ABS_W = BW_PSUM + 4;
  localparam int unsigned DIV_W = ABS_W - NORM_SHIFT;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSum  = 2'd1,
    StDiv  = 2'd2,
    StDone = 2'd3
  } norm_state_e;

endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               load operands (the setup cycle); iterations follow
//   dividend, divisor   unsigned operands, sampled on start
//   done                one-cycle pulse once quotient/div_zero are valid
//   quotient            dividend / divisor (0 when the divisor is 0)
//   div_zero            the divisor of the last operation was 0
// One operation takes 1 + QuoW cycles from the start edge to the done pulse being visible.
module serial_divider
  import norm_pkg::*;
#(
  parameter int unsigned DvdW = BW_PSUM + 1,
  parameter int unsigned DivW = DIV_W,
  parameter int unsigned QuoW = BW_PSUM
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [DvdW-1:0] dividend,
  input  logic [DivW-1:0] divisor,
  output logic            done,
  output logic [QuoW-1:0] quotient,
  output logic            div_zero
);

  localparam int unsigned CntW = (QuoW > 1) ? $clog2(QuoW) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(QuoW - 1);

  // dvd_q shifts dividend bits out of its MSB and quotient bits into its LSB.
  logic [QuoW-1:0] dvd_q, dvd_d;
  logic [DivW-1:0] rem_q, rem_d, dvs_q;
  logic [CntW-1:0] cnt_q;
  logic            run_q, done_q, dz_q;
  logic [DivW:0]   shifted;
  logic            fits;

  always_comb begin
    shifted = {rem_q, dvd_q[QuoW-1]};
    fits    = shifted >= {1'b0, dvs_q};
    rem_d   = fits ? DivW'(shifted - {1'b0, dvs_q}) : shifted[DivW-1:0];
    dvd_d   = {dvd_q[QuoW-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvd_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        dvd_q <= dividend[QuoW-1:0];
        // Dividend bits above QuoW seed the remainder; they are 0 for any real entry
        // magnitude, so QuoW iterations produce the full quotient.
        rem_q <= DivW'(dividend[DvdW-1:QuoW]);
        dvs_q <= divisor;
        dz_q  <= (divisor == '0);
        cnt_q <= '0;
        run_q <= 1'b1;
      end else if (run_q) begin
        dvd_q <= dvd_d;
        rem_q <= rem_d;
        cnt_q <= cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done     = done_q;
  assign quotient = dz_q ? '0 : dvd_q;
  assign div_zero = dz_q;

endmodule

// File: rtl/psum_norm_unit.sv
// Normalizes one row of signed partial sums: each entry is divided by
// (sum of |entry|) >> norm_shift using one shared serial divider.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     row input handshake; in_data entry 0 is the MSB slice
//   out_valid/out_ready   result handshake; out_data packed like in_data
//   div_zero              divisor of the presented result was 0 (all entries 0)
//   busy                  unit is not idle
// Accept edge to out_valid: 1 + col + col*(bw_psum+1) cycles.
module psum_norm_unit
  import norm_pkg::*;
#(
  parameter int unsigned bw_psum    = BW_PSUM,
  parameter int unsigned col        = COL,
  parameter int unsigned norm_shift = NORM_SHIFT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [bw_psum*col-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [bw_psum*col-1:0] out_data,
  output logic                   div_zero,
  output logic                   busy
);

  localparam int unsigned AbsW = bw_psum + 4;
  localparam int unsigned DivW = AbsW - norm_shift;
  localparam int unsigned IdxW = (col > 1) ? $clog2(col) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(col - 1);

  norm_state_e              state_q, state_d;
  logic [bw_psum*col-1:0]   data_q, data_d;
  logic [bw_psum-1:0]       entries [col];
  logic [bw_psum-1:0]       res_q [col];
  logic [bw_psum-1:0]       res_d [col];
  // Magnitudes only, so the running sum never goes negative.
  logic [AbsW-1:0]          abs_sum_q, abs_sum_d;
  logic [DivW-1:0]          divisor_q, divisor_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic                     first_q, first_d;
  logic                     div_zero_q, div_zero_d;

  logic                     div_start, div_done, div_dz;
  logic [bw_psum:0]         div_dividend;
  logic [bw_psum-1:0]       div_quot;

  // One extra bit so the most negative entry maps to its true magnitude.
  function automatic logic [bw_psum:0] mag(input logic [bw_psum-1:0] v);
    if (v[bw_psum-1]) return ~{1'b1, v} + (bw_psum + 1)'(1);
    return {1'b0, v};
  endfunction

  for (genvar g = 0; g < col; g++) begin : g_pack
    assign entries[g]                                = data_q[(col-g)*bw_psum-1 -: bw_psum];
    assign out_data[(col-g)*bw_psum-1 -: bw_psum]    = res_q[g];
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    res_d      = res_q;
    abs_sum_d  = abs_sum_q;
    divisor_d  = divisor_q;
    idx_d      = idx_q;
    first_d    = first_q;
    div_zero_d = div_zero_q;
    div_start  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d    = in_data;
          abs_sum_d = '0;
          idx_d     = '0;
          state_d   = StSum;
        end
      end
      StSum: begin
        abs_sum_d = abs_sum_q + AbsW'(mag(entries[idx_q]));
        if (idx_q == LastIdx) begin
          idx_d     = '0;
          divisor_d = abs_sum_d[AbsW-1:norm_shift];
          first_d   = 1'b1;
          state_d   = StDiv;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDiv: begin
        if (first_q) begin
          div_start = 1'b1;
          first_d   = 1'b0;
        end else if (div_done) begin
          // Capture this entry and launch the next one on the same edge, keeping the
          // per-entry period at setup + bw_psum iterations.
          res_d[idx_q] = entries[idx_q][bw_psum-1] ? bw_psum'(0) - div_quot : div_quot;
          if (idx_q == LastIdx) begin
            div_zero_d = div_dz;
            state_d    = StDone;
          end else begin
            idx_d     = idx_q + IdxW'(1);
            div_start = 1'b1;
          end
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Operand for the entry being launched, hence indexed by the next index.
  assign div_dividend = mag(entries[idx_d]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      data_q     <= '0;
      res_q      <= '{default: '0};
      abs_sum_q  <= '0;
      divisor_q  <= '0;
      idx_q      <= '0;
      first_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      res_q      <= res_d;
      abs_sum_q  <= abs_sum_d;
      divisor_q  <= divisor_d;
      idx_q      <= idx_d;
      first_q    <= first_d;
      div_zero_q <= div_zero_d;
    end
  end

  serial_divider #(
    .DvdW(bw_psum + 1),
    .DivW(DivW),
    .QuoW(bw_psum)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .start   (div_start),
    .dividend(div_dividend),
    .divisor (divisor_q),
    .done    (div_done),
    .quotient(div_quot),
    .div_zero(div_dz)
  );

  assign in_ready  = (state_q == StIdle) && !reset;
  assign out_valid = (state_q == StDone);
  assign div_zero  = div_zero_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_psum_norm_unit.sv
module tb_psum_norm_unit;

  localparam int BW  = 20;
  localparam int COL = 8;
  localparam int NS  = 7;
  localparam int W   = BW * COL;
  localparam int LAT = 1 + COL + COL * (BW + 1);

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         div_zero;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  int ent  [COL];
  int expv [COL];

  psum_norm_unit dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .div_zero (div_zero),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // sel 0 packs ent[], sel 1 packs expv[]
  function automatic logic [W-1:0] pack_arr(input int sel);
    logic [W-1:0]  p;
    logic [31:0]   t;
    p = '0;
    for (int i = 0; i < COL; i++) begin
      t = (sel == 0) ? ent[i] : expv[i];
      p[(COL-i)*BW-1 -: BW] = t[BW-1:0];
    end
    return p;
  endfunction

  // Reference: plain integer arithmetic on the whole row.
  function automatic logic [W-1:0] model(input logic [W-1:0] row, output bit dz);
    logic [W-1:0]  p;
    logic [BW-1:0] s;
    logic [31:0]   t;
    int            e [COL];
    int            sum;
    int            d;
    sum = 0;
    for (int i = 0; i < COL; i++) begin
      s    = row[(COL-i)*BW-1 -: BW];
      e[i] = $signed(s);
      sum += (e[i] < 0) ? -e[i] : e[i];
    end
    d  = sum >>> NS;
    dz = (d == 0);
    p  = '0;
    for (int i = 0; i < COL; i++) begin
      t = dz ? 0 : e[i] / d;
      p[(COL-i)*BW-1 -: BW] = t[BW-1:0];
    end
    return p;
  endfunction

  // Present one row, then count cycles from the accept edge until out_valid (bounded).
  task automatic send_and_wait(input logic [W-1:0] row, output int lat, output bit got);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b1;
    in_data  = row;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = {W{1'b1}};
    lat = 0;
    got = 1'b0;
    while (!got && lat < LAT + 40) begin
      @(posedge clk); #1;
      lat++;
      got = out_valid;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_cmp++; if (div_zero !== 1'b0) begin n_bad++; $display("FAIL reset_div_zero got %b want 0", div_zero); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    reset = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    int           lat;
    bit           got;
    bit           edz;
    logic [W-1:0] row;
    logic [W-1:0] exp_row;
    for (int sc = 0; sc < 5; sc++) begin
      for (int i = 0; i < COL; i++) begin ent[i] = 0; expv[i] = 0; end
      edz = 1'b0;
      case (sc)
        0: begin ent[0] = 256; expv[0] = 128; end
        1: begin ent[0] = -300; ent[1] = 1000; expv[0] = -30; expv[1] = 100; end
        2: for (int i = 0; i < COL; i++) begin ent[i] = -128; expv[i] = -16; end
        3: begin ent[0] = -524288; expv[0] = -128; end
        default: begin ent[0] = 100; edz = 1'b1; end
      endcase
      row     = pack_arr(0);
      exp_row = pack_arr(1);
      send_and_wait(row, lat, got);
      n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL dir%0d_timeout out_valid %b want 1", sc, got); end
      n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL dir%0d_latency got %0d want %0d", sc, lat, LAT); end
      n_cmp++; if (out_data !== exp_row) begin n_bad++; $display("FAIL dir%0d_data got %h want %h", sc, out_data, exp_row); end
      n_cmp++; if (div_zero !== edz) begin n_bad++; $display("FAIL dir%0d_div_zero got %b want %b", sc, div_zero, edz); end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    int           lat;
    bit           got;
    bit           edz;
    logic [W-1:0] row;
    logic [W-1:0] exp_row;
    for (int i = 0; i < COL; i++) ent[i] = $urandom_range(0, 4000) - 2000;
    row     = pack_arr(0);
    exp_row = model(row, edz);
    send_and_wait(row, lat, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL bp_timeout out_valid %b want 1", got); end
    // A new row offered while DONE must be ignored.
    in_valid = 1'b1;
    in_data  = ~row;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_data !== exp_row) begin n_bad++; $display("FAIL bp_hold_data c%0d got %h want %h", c, out_data, exp_row); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready c%0d got %b want 0", c, in_ready); end
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid c%0d got %b want 1", c, out_valid); end
    end
    in_valid = 1'b0;
    release_out();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_out_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bp_release_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_abort();
    int           lat;
    bit           got;
    bit           edz;
    int           seen;
    logic [W-1:0] row;
    logic [W-1:0] exp_row;
    for (int i = 0; i < COL; i++) ent[i] = 0;
    ent[0] = -300; ent[1] = 1000;
    row     = pack_arr(0);
    exp_row = model(row, edz);
    in_valid = 1'b1;
    in_data  = row;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL abort_in_ready_during got %b want 0", in_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL abort_in_ready_after got %b want 1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy); end
    seen = 0;
    for (int c = 0; c < LAT + 20; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL abort_no_output got %0d valid cycles want 0", seen); end
    send_and_wait(row, lat, got);
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL abort_next_latency got %0d want %0d", lat, LAT); end
    n_cmp++; if (out_data !== exp_row) begin n_bad++; $display("FAIL abort_next_data got %h want %h", out_data, exp_row); end
    n_cmp++; if (div_zero !== edz) begin n_bad++; $display("FAIL abort_next_div_zero got %b want %b", div_zero, edz); end
    release_out();
  endtask

  task automatic test_random();
    int            lat;
    bit            got;
    bit            edz;
    int            kind;
    logic [BW-1:0] r;
    logic [W-1:0]  row;
    logic [W-1:0]  exp_row;
    for (int n = 0; n < 10; n++) begin
      kind = $urandom_range(0, 2);
      for (int i = 0; i < COL; i++) begin
        r = BW'($urandom);
        case (kind)
          0: ent[i] = $signed(r);
          1: ent[i] = $urandom_range(0, 40) - 20;
          default: case ($urandom_range(0, 3))
            0: ent[i] = -524288;
            1: ent[i] = 524287;
            2: ent[i] = 0;
            default: ent[i] = $urandom_range(0, 20000) - 10000;
          endcase
        endcase
      end
      row     = pack_arr(0);
      exp_row = model(row, edz);
      send_and_wait(row, lat, got);
      n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL rnd%0d_latency got %0d want %0d", n, lat, LAT); end
      n_cmp++; if (out_data !== exp_row) begin n_bad++; $display("FAIL rnd%0d_data got %h want %h", n, out_data, exp_row); end
      n_cmp++; if (div_zero !== edz) begin n_bad++; $display("FAIL rnd%0d_div_zero got %b want %b", n, div_zero, edz); end
      release_out();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
